// File: rtl/cc_random_gen.sv
// Pseudo-random value source: free-running 16-bit Fibonacci LFSR with seed load and
// bounded rejection sampling into [0, LIMIT), falling back to 0 after MAXTRIES rejections.
module cc_random_gen #(
  parameter int unsigned RANDOMGEN_RANDOMWIDTH = 8,
  parameter int unsigned RANDOMGEN_LIMIT       = 160,
  parameter int unsigned RANDOMGEN_MAXTRIES    = 8,
  parameter logic [15:0] RANDOMGEN_SEEDDEFAULT = 16'hACE1
) (
  input  logic                             CC_RANDOMGEN_CLOCK_50,
  input  logic                             CC_RANDOMGEN_RESET_InHigh,
  input  logic                             CC_RANDOMGEN_req_In,
  input  logic                             CC_RANDOMGEN_seedload_In,
  input  logic [15:0]                      CC_RANDOMGEN_seed_InBUS,
  output logic [RANDOMGEN_RANDOMWIDTH-1:0] CC_RANDOMGEN_random_OutBUS,
  output logic                             CC_RANDOMGEN_valid_Out,
  output logic                             CC_RANDOMGEN_timeout_Out,
  output logic                             CC_RANDOMGEN_busy_Out
);

  localparam int unsigned TriesWidth = $clog2(RANDOMGEN_MAXTRIES + 1);
  localparam logic [TriesWidth-1:0] LastTry = TriesWidth'(RANDOMGEN_MAXTRIES - 1);
  localparam logic [16:0] LimitExt = 17'(RANDOMGEN_LIMIT);

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  state_e                           state_q, state_d;
  logic [15:0]                      lfsr_q, lfsr_d;
  logic [TriesWidth-1:0]            tries_q, tries_d;
  logic [RANDOMGEN_RANDOMWIDTH-1:0] random_q, random_d;
  logic                             valid_q, valid_d;
  logic                             timeout_q, timeout_d;
  logic                             busy_q, busy_d;
  logic                             feedback;
  logic [RANDOMGEN_RANDOMWIDTH-1:0] cand;
  logic                             cand_ok;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // Candidate is the pre-edge LFSR value, so a seed loaded with req is the first candidate.
  assign cand     = lfsr_q[RANDOMGEN_RANDOMWIDTH-1:0];
  assign cand_ok  = 17'(cand) < LimitExt;

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    random_d  = random_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    if (CC_RANDOMGEN_seedload_In) begin
      // An all-zero seed would lock the LFSR up, so substitute the default.
      lfsr_d = (CC_RANDOMGEN_seed_InBUS == 16'h0000) ? RANDOMGEN_SEEDDEFAULT
                                                      : CC_RANDOMGEN_seed_InBUS;
    end else begin
      lfsr_d = {lfsr_q[14:0], feedback};
    end

    unique case (state_q)
      StIdle: begin
        if (CC_RANDOMGEN_req_In) begin
          state_d = StGen;
          tries_d = '0;
        end
      end
      StGen: begin
        if (cand_ok) begin
          random_d = cand;
          valid_d  = 1'b1;
          state_d  = StIdle;
        end else if (tries_q == LastTry) begin
          random_d  = '0;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StGen);
  end

  always_ff @(posedge CC_RANDOMGEN_CLOCK_50) begin
    if (CC_RANDOMGEN_RESET_InHigh) begin
      state_q   <= StIdle;
      lfsr_q    <= RANDOMGEN_SEEDDEFAULT;
      tries_q   <= '0;
      random_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      tries_q   <= tries_d;
      random_q  <= random_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign CC_RANDOMGEN_random_OutBUS = random_q;
  assign CC_RANDOMGEN_valid_Out     = valid_q;
  assign CC_RANDOMGEN_timeout_Out   = timeout_q;
  assign CC_RANDOMGEN_busy_Out      = busy_q;

endmodule

// File: tb/tb_cc_random_gen.sv
// Directed bench for cc_random_gen: dut_a uses MAXTRIES=8, dut_b MAXTRIES=7 on shared stimulus.
module tb_cc_random_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        seedload;
  logic [15:0] seed;

  logic [7:0] rand_a, rand_b;
  logic       valid_a, valid_b, timeout_a, timeout_b, busy_a, busy_b;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  cc_random_gen #(
    .RANDOMGEN_RANDOMWIDTH(8),
    .RANDOMGEN_LIMIT(160),
    .RANDOMGEN_MAXTRIES(8),
    .RANDOMGEN_SEEDDEFAULT(16'hACE1)
  ) dut_a (
    .CC_RANDOMGEN_CLOCK_50     (clk),
    .CC_RANDOMGEN_RESET_InHigh (rst),
    .CC_RANDOMGEN_req_In       (req),
    .CC_RANDOMGEN_seedload_In  (seedload),
    .CC_RANDOMGEN_seed_InBUS   (seed),
    .CC_RANDOMGEN_random_OutBUS(rand_a),
    .CC_RANDOMGEN_valid_Out    (valid_a),
    .CC_RANDOMGEN_timeout_Out  (timeout_a),
    .CC_RANDOMGEN_busy_Out     (busy_a)
  );

  cc_random_gen #(
    .RANDOMGEN_RANDOMWIDTH(8),
    .RANDOMGEN_LIMIT(160),
    .RANDOMGEN_MAXTRIES(7),
    .RANDOMGEN_SEEDDEFAULT(16'hACE1)
  ) dut_b (
    .CC_RANDOMGEN_CLOCK_50     (clk),
    .CC_RANDOMGEN_RESET_InHigh (rst),
    .CC_RANDOMGEN_req_In       (req),
    .CC_RANDOMGEN_seedload_In  (seedload),
    .CC_RANDOMGEN_seed_InBUS   (seed),
    .CC_RANDOMGEN_random_OutBUS(rand_b),
    .CC_RANDOMGEN_valid_Out    (valid_b),
    .CC_RANDOMGEN_timeout_Out  (timeout_b),
    .CC_RANDOMGEN_busy_Out     (busy_b)
  );

  // Inputs set before tick are sampled at its posedge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; seedload = 1'b0; seed = 16'h0000;
    tick(); tick();
    total++;
    if (dut_a.lfsr_q !== 16'hACE1) $display("FAIL reset_lfsr got %h exp ACE1", dut_a.lfsr_q);
    else pass_cnt++;
    total++;
    if ({rand_a, valid_a, timeout_a, busy_a} !== 11'h0)
      $display("FAIL reset_outs got r=%h v=%b t=%b b=%b exp 0", rand_a, valid_a, timeout_a, busy_a);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total++;
    if (dut_a.lfsr_q !== 16'h59C3) $display("FAIL lfsr_step1 got %h exp 59C3", dut_a.lfsr_q);
    else pass_cnt++;
    tick();
    total++;
    if (dut_a.lfsr_q !== 16'hB387) $display("FAIL lfsr_step2 got %h exp B387", dut_a.lfsr_q);
    else pass_cnt++;
    tick();
    total++;
    if ({rand_a, valid_a, busy_a} !== 10'h0)
      $display("FAIL idle_outs got r=%h v=%b b=%b exp 0", rand_a, valid_a, busy_a);
    else pass_cnt++;
  endtask

  task automatic test_min_latency();
    seedload = 1'b1; seed = 16'h0001; req = 1'b1;
    tick();  // edge k
    seedload = 1'b0; req = 1'b0;
    total++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0)
      $display("FAIL min_lat_busy got b=%b v=%b exp b=1 v=0", busy_a, valid_a);
    else pass_cnt++;
    tick();  // k+1
    total++;
    if ({valid_a, timeout_a, busy_a, rand_a} !== {3'b100, 8'h01})
      $display("FAIL min_lat_accept got v=%b t=%b b=%b r=%h exp v=1 t=0 b=0 r=01",
               valid_a, timeout_a, busy_a, rand_a);
    else pass_cnt++;
    tick();  // k+2
    total++;
    if (valid_a !== 1'b0) $display("FAIL valid_pulse got %b exp 0", valid_a);
    else pass_cnt++;
    req = 1'b1;
    tick();  // k+3
    req = 1'b0;
    tick();  // k+4
    total++;
    if (valid_a !== 1'b1 || rand_a !== 8'h08)
      $display("FAIL second_req got v=%b r=%h exp v=1 r=08", valid_a, rand_a);
    else pass_cnt++;
    tick();
  endtask

  // Seed 00FF: candidates FF FE FC F8 F1 E3 C6 rejected, 8D accepted on the 8th edge.
  task automatic test_rejection_and_timeout();
    int busy_cycles = 0;
    int early_valid = 0;
    seedload = 1'b1; seed = 16'h00FF; req = 1'b1;
    tick();  // edge k
    seedload = 1'b0; req = 1'b0;
    busy_cycles += busy_a;
    for (int i = 1; i <= 7; i++) begin
      tick();
      busy_cycles += busy_a;
      early_valid += valid_a;
      if (i < 7) early_valid += valid_b;
    end
    total++;
    if (early_valid != 0) $display("FAIL reject_no_valid got %0d pulses exp 0", early_valid);
    else pass_cnt++;
    total++;
    if ({valid_b, timeout_b, busy_b, rand_b} !== {3'b110, 8'h00})
      $display("FAIL fallback got v=%b t=%b b=%b r=%h exp v=1 t=1 b=0 r=00",
               valid_b, timeout_b, busy_b, rand_b);
    else pass_cnt++;
    tick();  // k+8
    total++;
    if ({valid_a, timeout_a, busy_a, rand_a} !== {3'b100, 8'h8D})
      $display("FAIL last_try_accept got v=%b t=%b b=%b r=%h exp v=1 t=0 b=0 r=8D",
               valid_a, timeout_a, busy_a, rand_a);
    else pass_cnt++;
    total++;
    if (busy_cycles != 8) $display("FAIL busy_len got %0d exp 8", busy_cycles);
    else pass_cnt++;
    total++;
    if (valid_b !== 1'b0 || timeout_b !== 1'b0)
      $display("FAIL timeout_pulse got v=%b t=%b exp 0 0", valid_b, timeout_b);
    else pass_cnt++;
    tick();
  endtask

  // Zero seed loads ACE1: E1, C3 rejected, 87 accepted at k+3; req held during GEN is ignored.
  task automatic test_zero_seed_and_ignore_req();
    int valids = 0;
    seedload = 1'b1; seed = 16'h0000; req = 1'b1;
    tick();  // edge k
    seedload = 1'b0;
    total++;
    if (dut_a.lfsr_q !== 16'hACE1) $display("FAIL zero_seed got %h exp ACE1", dut_a.lfsr_q);
    else pass_cnt++;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) req = 1'b0;  // req held through the returning edge k+3
      valids += valid_a;
      if (i == 3) begin
        total++;
        if (valid_a !== 1'b1 || rand_a !== 8'h87)
          $display("FAIL zero_seed_val got v=%b r=%h exp v=1 r=87", valid_a, rand_a);
        else pass_cnt++;
      end
      if (i == 4) begin
        total++;
        if (busy_a !== 1'b0) $display("FAIL req_on_return got busy=%b exp 0", busy_a);
        else pass_cnt++;
      end
    end
    total++;
    if (valids != 1) $display("FAIL no_queue got %0d pulses exp 1", valids);
    else pass_cnt++;
    total++;
    if (rand_a !== 8'h87) $display("FAIL hold_value got %h exp 87", rand_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_gen();
    int valids = 0;
    seedload = 1'b1; seed = 16'h00FF; req = 1'b1;
    tick();  // edge k
    seedload = 1'b0; req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();  // k+3
    total++;
    if ({valid_a, busy_a, rand_a} !== 10'h0 || dut_a.lfsr_q !== 16'hACE1)
      $display("FAIL reset_mid_gen got v=%b b=%b r=%h lfsr=%h exp 0 0 00 ACE1",
               valid_a, busy_a, rand_a, dut_a.lfsr_q);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      valids += valid_a + busy_a;
    end
    total++;
    if (valids != 0) $display("FAIL abort_no_valid got %0d exp 0", valids);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_rejection_and_timeout();
    test_zero_seed_and_ignore_req();
    test_reset_mid_gen();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
